// File: rtl/rf_pkg.sv
// Shared types and constants for the integer register-file access controller.
package rf_pkg;

  localparam int NREG        = 32;
  localparam int REG_IDX_W   = 5;
  localparam int D_WIDTH_DEF = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } ctrl_state_t;

  typedef enum logic {
    WB_MEM = 1'b0,
    WB_ALU = 1'b1
  } wb_src_t;

endpackage

// File: rtl/rf_wb_arb.sv
// Two-requester round-robin arbiter for the single register-file write port,
// with the rd/data mux for the winning requester.
module rf_wb_arb #(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_valid,
  input  logic [4:0]         alu_rd,
  input  logic [D_WIDTH-1:0] alu_data,
  output logic               alu_ready,
  input  logic               mem_valid,
  input  logic [4:0]         mem_rd,
  input  logic [D_WIDTH-1:0] mem_data,
  output logic               mem_ready,
  output logic               grant,
  output logic [4:0]         grant_rd,
  output logic [D_WIDTH-1:0] grant_data
);
  import rf_pkg::*;

  wb_src_t ptr_q;
  logic    sel_mem;

  always_comb begin
    sel_mem    = mem_valid & (~alu_valid | (ptr_q == WB_MEM));
    grant      = alu_valid | mem_valid;
    mem_ready  = sel_mem;
    alu_ready  = alu_valid & ~sel_mem;
    grant_rd   = '0;
    grant_data = '0;
    if (sel_mem) begin
      grant_rd   = mem_rd;
      grant_data = mem_data;
    end else if (alu_valid) begin
      grant_rd   = alu_rd;
      grant_data = alu_data;
    end
  end

  // The pointer only moves on contention, toward the side that just lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= WB_MEM;
    end else if (alu_valid && mem_valid) begin
      ptr_q <= (ptr_q == WB_MEM) ? WB_ALU : WB_MEM;
    end
  end

endmodule

// File: rtl/rf_access_ctrl.sv
// Register-file access sequencer: issues reads for decoded instructions, holds
// operands for execute, scoreboards in-flight destinations and arbitrates writeback.
module rf_access_ctrl #(
  parameter int D_WIDTH = 32,
  parameter int NREG    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dec_valid,
  output logic               dec_ready,
  input  logic [4:0]         dec_rs1,
  input  logic [4:0]         dec_rs2,
  input  logic [4:0]         dec_rd,
  input  logic               dec_use_rs1,
  input  logic               dec_use_rs2,
  input  logic               dec_wr_rd,
  output logic               op_valid,
  input  logic               op_ready,
  input  logic               flush,
  output logic [4:0]         rf_rs1,
  output logic [4:0]         rf_rs2,
  output logic [4:0]         rf_rd,
  output logic               rf_regLd,
  output logic               rf_regStr,
  output logic [D_WIDTH-1:0] rf_WBDat,
  input  logic               alu_wb_valid,
  output logic               alu_wb_ready,
  input  logic [4:0]         alu_wb_rd,
  input  logic [D_WIDTH-1:0] alu_wb_data,
  input  logic               mem_wb_valid,
  output logic               mem_wb_ready,
  input  logic [4:0]         mem_wb_rd,
  input  logic [D_WIDTH-1:0] mem_wb_data,
  output logic [NREG-1:0]    busy_vec,
  output logic               wb_err
);
  import rf_pkg::*;

  ctrl_state_t     state_q, state_d;
  logic [NREG-1:0] busy_q, busy_d, set_mask, clr_mask;
  reg_idx_t        held_rd_q;
  logic            held_wr_q;
  logic            wb_err_q, err_set;
  logic            hazard, issue, flush_hold;
  logic            grant;
  reg_idx_t        grant_rd;

  rf_wb_arb #(.D_WIDTH(D_WIDTH)) u_wb_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_wb_valid),
    .alu_rd     (alu_wb_rd),
    .alu_data   (alu_wb_data),
    .alu_ready  (alu_wb_ready),
    .mem_valid  (mem_wb_valid),
    .mem_rd     (mem_wb_rd),
    .mem_data   (mem_wb_data),
    .mem_ready  (mem_wb_ready),
    .grant      (grant),
    .grant_rd   (grant_rd),
    .grant_data (rf_WBDat)
  );

  // Issue control and FSM next state
  always_comb begin
    hazard = (dec_use_rs1 & busy_q[dec_rs1]) |
             (dec_use_rs2 & busy_q[dec_rs2]) |
             (dec_wr_rd   & busy_q[dec_rd]);
    issue  = dec_valid & ~hazard & ~flush &
             ((state_q == IDLE) | ((state_q == HOLD) & op_ready));
    flush_hold = flush & (state_q == HOLD);
    state_d = state_q;
    case (state_q)
      IDLE: if (issue) state_d = HOLD;
      HOLD: begin
        if (flush)                    state_d = IDLE;
        else if (op_ready && !issue)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scoreboard: a writeback always lands while its rd is still marked busy,
  // so a clear of an idle entry means a stray or duplicated writeback.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue && dec_wr_rd && (dec_rd != '0)) set_mask[dec_rd] = 1'b1;
    if (grant && (grant_rd != '0))            clr_mask[grant_rd] = 1'b1;
    if (flush_hold && held_wr_q)              clr_mask[held_rd_q] = 1'b1;
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
    err_set   = grant & (grant_rd != '0) & ~busy_q[grant_rd];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= '0;
      held_rd_q <= '0;
      held_wr_q <= 1'b0;
      wb_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      if (err_set) wb_err_q <= 1'b1;
      if (issue) begin
        held_rd_q <= dec_rd;
        held_wr_q <= dec_wr_rd & (dec_rd != '0);
      end else if (state_d == IDLE) begin
        held_wr_q <= 1'b0;
      end
    end
  end

  assign dec_ready = issue;
  assign op_valid  = (state_q == HOLD);
  assign rf_regLd  = issue;
  assign rf_rs1    = dec_rs1;
  assign rf_rs2    = dec_rs2;
  assign rf_rd     = grant_rd;
  assign rf_regStr = grant;
  assign busy_vec  = busy_q;
  assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed bench for rf_access_ctrl with a small behavioural register file model.
module tb_rf_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid, dec_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_use_rs1, dec_use_rs2, dec_wr_rd;
  logic        op_valid, op_ready, flush;
  logic [4:0]  rf_rs1, rf_rs2, rf_rd;
  logic        rf_regLd, rf_regStr;
  logic [31:0] rf_WBDat;
  logic        alu_wb_valid, alu_wb_ready;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        mem_wb_valid, mem_wb_ready;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_data;
  logic [31:0] busy_vec;
  logic        wb_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] regs [32];
  logic [31:0] rd1_q, rd2_q;

  always #5 clk = ~clk;

  rf_access_ctrl #(.D_WIDTH(32), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_wr_rd(dec_wr_rd),
    .op_valid(op_valid), .op_ready(op_ready), .flush(flush),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd),
    .rf_regLd(rf_regLd), .rf_regStr(rf_regStr), .rf_WBDat(rf_WBDat),
    .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
    .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .mem_wb_valid(mem_wb_valid), .mem_wb_ready(mem_wb_ready),
    .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .busy_vec(busy_vec), .wb_err(wb_err)
  );

  // Register file: registered read on regLd, write on regStr, no bypass.
  always @(posedge clk) begin
    if (rf_regStr && rf_rd != 5'd0) regs[rf_rd] <= rf_WBDat;
    if (rf_regLd) begin
      rd1_q <= (rf_rs1 == 5'd0) ? 32'd0 : regs[rf_rs1];
      rd2_q <= (rf_rs2 == 5'd0) ? 32'd0 : regs[rf_rs2];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    dec_use_rs1 = 0; dec_use_rs2 = 0; dec_wr_rd = 0;
    op_ready = 0; flush = 0;
    alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
    mem_wb_valid = 0; mem_wb_rd = 0; mem_wb_data = 0;
  endtask

  task automatic set_dec(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic wr);
    dec_valid = 1; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
    dec_use_rs1 = u1; dec_use_rs2 = u2; dec_wr_rd = wr;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    settle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    rd1_q = 0; rd2_q = 0;
    do_reset();
    chk("reset_op_valid", {31'd0, op_valid}, 32'd0);
    chk("reset_busy", busy_vec, 32'd0);
    chk("reset_wb_err", {31'd0, wb_err}, 32'd0);
    chk("reset_regstr", {31'd0, rf_regStr}, 32'd0);

    // Reset in the middle of a HOLD with x5 busy
    set_dec(5'd1, 5'd2, 5'd5, 1, 1, 1);
    settle();
    chk("first_issue_ready", {31'd0, dec_ready}, 32'd1);
    step();
    dec_valid = 0;
    settle();
    chk("hold_op_valid", {31'd0, op_valid}, 32'd1);
    chk("hold_busy5", busy_vec, 32'h0000_0020);
    rst_n = 0;
    settle();
    chk("async_rst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("async_rst_busy", busy_vec, 32'd0);
    step();
    rst_n = 1;
    set_dec(5'd5, 5'd0, 5'd6, 1, 0, 1);
    settle();
    chk("post_rst_dec_ready", {31'd0, dec_ready}, 32'd1);
    dec_valid = 0;
    settle();

    // RAW stall on x5 resolved by ALU writeback
    set_dec(5'd1, 5'd2, 5'd5, 1, 1, 1);
    settle();
    step();
    set_dec(5'd5, 5'd0, 5'd6, 1, 0, 1);
    op_ready = 1;
    settle();
    chk("raw_stall", {31'd0, dec_ready}, 32'd0);
    step();
    op_ready = 0;
    alu_wb_valid = 1; alu_wb_rd = 5'd5; alu_wb_data = 32'hDEADBEEF;
    settle();
    chk("raw_alu_ready", {31'd0, alu_wb_ready}, 32'd1);
    chk("raw_wbdat", rf_WBDat, 32'hDEADBEEF);
    chk("raw_stall_during_write", {31'd0, dec_ready}, 32'd0);
    step();
    alu_wb_valid = 0;
    settle();
    chk("raw_busy_cleared", busy_vec, 32'd0);
    chk("raw_issue_ready", {31'd0, dec_ready}, 32'd1);
    chk("raw_regld", {31'd0, rf_regLd}, 32'd1);
    chk("raw_rf_rs1", {27'd0, rf_rs1}, 32'd5);
    step();
    dec_valid = 0;
    settle();
    chk("raw_operand", rd1_q, 32'hDEADBEEF);
    chk("raw_busy6", busy_vec, 32'h0000_0040);
    chk("raw_no_err", {31'd0, wb_err}, 32'd0);

    // Back-to-back independent instructions with op_ready held
    op_ready = 1;
    for (int i = 0; i < 3; i++) begin
      set_dec(5'd1, 5'd2, 5'(10 + i), 1, 1, 1);
      settle();
      chk("b2b_ready", {31'd0, dec_ready}, 32'd1);
      step();
      chk("b2b_op_valid", {31'd0, op_valid}, 32'd1);
    end
    dec_valid = 0;
    settle();
    chk("b2b_busy", busy_vec, 32'h0000_1C40);
    step();
    op_ready = 0;
    settle();
    chk("b2b_drain", {31'd0, op_valid}, 32'd0);

    // Round-robin arbitration from reset
    do_reset();
    alu_wb_valid = 1; alu_wb_rd = 5'd3; alu_wb_data = 32'hA3A3_0003;
    mem_wb_valid = 1; mem_wb_rd = 5'd4; mem_wb_data = 32'h4444_0004;
    settle();
    chk("arb1_mem_ready", {31'd0, mem_wb_ready}, 32'd1);
    chk("arb1_alu_ready", {31'd0, alu_wb_ready}, 32'd0);
    chk("arb1_rd", {27'd0, rf_rd}, 32'd4);
    chk("arb1_data", rf_WBDat, 32'h4444_0004);
    step();
    mem_wb_rd = 5'd6; mem_wb_data = 32'h6666_0006;
    settle();
    chk("arb2_alu_ready", {31'd0, alu_wb_ready}, 32'd1);
    chk("arb2_mem_ready", {31'd0, mem_wb_ready}, 32'd0);
    chk("arb2_rd", {27'd0, rf_rd}, 32'd3);
    chk("arb2_err_nonbusy", {31'd0, wb_err}, 32'd1);
    step();
    alu_wb_rd = 5'd7; alu_wb_data = 32'h7777_0007;
    settle();
    chk("arb3_mem_ready", {31'd0, mem_wb_ready}, 32'd1);
    chk("arb3_rd", {27'd0, rf_rd}, 32'd6);
    step();
    alu_wb_valid = 0; mem_wb_valid = 0;
    settle();
    chk("arb_idle_regstr", {31'd0, rf_regStr}, 32'd0);
    chk("arb_idle_rd", {27'd0, rf_rd}, 32'd0);
    chk("arb_idle_data", rf_WBDat, 32'd0);

    // Flush of a held instruction releases its destination
    do_reset();
    set_dec(5'd1, 5'd2, 5'd7, 1, 1, 1);
    settle();
    step();
    chk("flush_busy7", busy_vec, 32'h0000_0080);
    flush = 1;
    set_dec(5'd1, 5'd2, 5'd9, 1, 1, 1);
    settle();
    chk("flush_blocks_issue", {31'd0, dec_ready}, 32'd0);
    step();
    flush = 0; dec_valid = 0;
    settle();
    chk("flush_busy_clear", busy_vec, 32'd0);
    chk("flush_op_valid", {31'd0, op_valid}, 32'd0);
    chk("flush_no_err", {31'd0, wb_err}, 32'd0);
    alu_wb_valid = 1; alu_wb_rd = 5'd7; alu_wb_data = 32'h1;
    step();
    alu_wb_valid = 0;
    settle();
    chk("flush_late_wb_err", {31'd0, wb_err}, 32'd1);

    // x0 destination never enters the scoreboard
    do_reset();
    set_dec(5'd1, 5'd2, 5'd0, 1, 1, 1);
    settle();
    chk("x0_issue", {31'd0, dec_ready}, 32'd1);
    step();
    dec_valid = 0;
    settle();
    chk("x0_busy", busy_vec, 32'd0);
    op_ready = 1;
    alu_wb_valid = 1; alu_wb_rd = 5'd0; alu_wb_data = 32'h55;
    settle();
    chk("x0_regstr", {31'd0, rf_regStr}, 32'd1);
    step();
    alu_wb_valid = 0; op_ready = 0;
    settle();
    chk("x0_no_err", {31'd0, wb_err}, 32'd0);
    chk("x0_busy_after", busy_vec, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_access_ctrl.md
Name: rf_access_ctrl

Overview:
Sequences the 32-entry integer register file for the in-order RISC-V core. Accepts decoded instructions and issues the register-file read. Holds the registered operands until execute accepts them. Tracks in-flight destinations in a 32-bit scoreboard to stall RAW/WAW hazards, and arbitrates the single write port between the ALU and load-unit writeback requesters.

Parameters:
D_WIDTH, 32, register/writeback data width
NREG, 32, architectural registers (index width 5, fixed)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
dec_valid  in  1  decoded instruction available
dec_ready  out  1  instruction accepted this cycle
dec_rs1  in  5  source 1 index
dec_rs2  in  5  source 2 index
dec_rd  in  5  destination index
dec_use_rs1  in  1  rs1 is read
dec_use_rs2  in  1  rs2 is read
dec_wr_rd  in  1  instruction writes rd
op_valid  out  1  rs1Out/rs2Out of regfile valid for execute
op_ready  in  1  execute consumes operands
flush  in  1  kill held instruction
rf_rs1  out  5  to regfile rs1
rf_rs2  out  5  to regfile rs2
rf_rd  out  5  to regfile rd
rf_regLd  out  1  to regfile regLd
rf_regStr  out  1  to regfile regStr
rf_WBDat  out  D_WIDTH  to regfile WBDat
alu_wb_valid  in  1  ALU result pending
alu_wb_ready  out  1  ALU write granted
alu_wb_rd  in  5  ALU dest
alu_wb_data  in  D_WIDTH  ALU result
mem_wb_valid  in  1  load result pending
mem_wb_ready  out  1  load write granted
mem_wb_rd  in  5  load dest
mem_wb_data  in  D_WIDTH  load data
busy_vec  out  32  scoreboard state
wb_err  out  1  sticky: writeback to non-busy rd≠0

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, busy_vec=0, op_valid=0, wb_err=0, RR pointer=MEM-first, held_rd=0, held_wr=0. Reset mid-operation drops any held instruction and clears the scoreboard.
- FSM states IDLE, HOLD. op_valid=1 iff state==HOLD.
- Hazard (combinational) = (dec_use_rs1 & busy[dec_rs1]) | (dec_use_rs2 & busy[dec_rs2]) | (dec_wr_rd & busy[dec_rd]). busy[0] is always 0.
- Issue condition: dec_valid & ~hazard & ~flush & (state==IDLE | (state==HOLD & op_ready)). dec_ready = issue condition.
- On issue: rf_regLd=1, rf_rs1/rf_rs2 = dec indices. Operands appear on the regfile outputs next cycle, giving 1-cycle read latency. Next state=HOLD. If dec_wr_rd & dec_rd≠0, set busy[dec_rd] at the edge; held_rd/held_wr capture it.
- HOLD & op_ready & no issue: go to IDLE.
- HOLD & ~op_ready: rf_regLd=0 so the regfile holds the operands stable.
- flush in HOLD: go to IDLE; clear busy[held_rd] if held_wr. flush in IDLE has no effect. flush blocks same-cycle issue.
- rf_regLd is 0 whenever no issue occurs.
- Writeback arbitration: at most one grant per cycle.
  - Both valid: grant the side the RR pointer names; the pointer flips to the other side after the grant.
  - Single valid: grant it; the pointer does not change.
  - Granted side: rf_regStr=1, rf_rd/rf_WBDat muxed from the winner. Its ready=1; the loser's ready=0 and it holds its request.
  - No valid: rf_regStr=0, rf_rd=0, rf_WBDat=0.
- On grant with rd≠0: clear busy[rd] at the edge. If busy[rd] was already 0, set wb_err (sticky until reset). Writeback to rd=0: regStr still asserted, no scoreboard effect.
- A write and a read of the same register in one cycle cannot occur: busy stays set during the write cycle, so the read stalls. The read then issues the following cycle and sees the new value, with no bypass.
- Set and clear of the same index in one cycle cannot occur because of the WAW stall. If set and clear of different indices coincide, both apply.
- The flush clear and a writeback clear of the same index in one cycle both clear; no wb_err is raised for that index that cycle.

Decomposition:
- Package rf_pkg: NREG, REG_IDX_W=5, D_WIDTH default, typedef reg_idx_t, enum ctrl_state_t {IDLE, HOLD}, enum wb_src_t {WB_MEM, WB_ALU}.
- Sub-module rf_wb_arb holds the two-requester round-robin arbiter plus the data/rd mux. It reports grant and granted rd to the scoreboard logic in the parent.

Test Plan:
- Reset: assert rst_n=0 mid-HOLD with busy[5]=1 → op_valid=0, busy_vec=0, dec_ready follows dec_valid next cycle.
- RAW stall: issue rd=5 (add), then next dec rs1=5 → dec_ready=0. ALU writes x5=0xDEADBEEF → cycle after write dec_ready=1, rf_regLd=1; operand reads 0xDEADBEEF.
- Back-to-back: op_ready held 1, three independent instructions → dec_ready=1 on three consecutive cycles, op_valid stays 1.
- Arbitration: ALU(rd=3) and MEM(rd=4) valid together from reset → MEM granted first, ALU next cycle; then both again → MEM first after ALU (pointer alternates).
- Flush: issue rd=7, flush in HOLD → busy[7]=0 next cycle, op_valid=0; later writeback to x7 sets wb_err=1.
- x0: issue rd=0 writing instruction → busy_vec stays 0; writeback rd=0 asserts rf_regStr, wb_err stays 0.
